div_iter: RTL

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting beside the EXE stage and feeding the pipeline forward/stall controller. It accepts a level-held request from EXE, computes the quotient or remainder over multiple cycles, and returns a one-cycle acknowledge with the result. The controller holds EXE stalled from request until acknowledge. A CSR redirect or WFI flush aborts an operation in flight.

---
 rtl/div_iter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU beside the EXE stage.
// Optional macro DIV_EARLY_OUT_EN: resolve divide-by-zero, overflow and |rs1| < |rs2| in one cycle.
package div_iter_pkg;
  typedef struct packed {
    logic div_req;
    logic div_ack;
  } div2fwd_t;
endpackage

module div_iter
  import div_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic [1:0]  div_op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        flush_i,
  output div2fwd_t    div2fwd_o,
  output logic [31:0] div_result_o,
  output logic        div_busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [32:0] rem_r;
  logic [31:0] dvd_r;
  logic [31:0] dvs_r;
  logic [31:0] result_r;
  logic [4:0]  cnt_r;
  logic        is_rem_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        dz_r;
  logic        ovf_r;

  logic        start_s;
  logic        is_signed_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic        dz_s;
  logic        ovf_s;
  logic [33:0] shift_s;
  logic [33:0] diff_s;
  logic [32:0] rem_nxt_s;
  logic [31:0] quo_nxt_s;
  logic [31:0] fin_q_s;
  logic [31:0] fin_r_s;
  logic [31:0] fin_s;
`ifdef DIV_EARLY_OUT_EN
  logic        early_s;
  logic [31:0] early_res_s;
`endif

  assign start_s     = div_req_i & ~flush_i;
  assign is_signed_s = ~div_op_i[0];
  assign a_neg_s     = is_signed_s & rs1_i[31];
  assign b_neg_s     = is_signed_s & rs2_i[31];
  assign a_mag_s     = a_neg_s ? (32'd0 - rs1_i) : rs1_i;
  assign b_mag_s     = b_neg_s ? (32'd0 - rs2_i) : rs2_i;
  assign dz_s        = (rs2_i == 32'd0);
  assign ovf_s       = is_signed_s & (rs1_i == 32'h8000_0000) & (rs2_i == 32'hFFFF_FFFF);

  assign div2fwd_o.div_req = start_s;
  assign div2fwd_o.div_ack = (state_r == DONE) & ~flush_i;
  assign div_result_o      = result_r;
  assign div_busy_o        = (state_r != IDLE);

  // One restoring step plus the sign fix-up applied to the final step's output
  always_comb begin
    shift_s   = {rem_r, dvd_r[31]};
    diff_s    = shift_s - {2'b00, dvs_r};
    rem_nxt_s = shift_s[32:0];
    quo_nxt_s = {dvd_r[30:0], 1'b0};
    if (!diff_s[33]) begin
      rem_nxt_s = diff_s[32:0];
      quo_nxt_s = {dvd_r[30:0], 1'b1};
    end else begin
      rem_nxt_s = shift_s[32:0];
      quo_nxt_s = {dvd_r[30:0], 1'b0};
    end

    // Zero divisor leaves |rs1| in rem, so the rs1-sign fix-up already yields rs1
    if (dz_r) begin
      fin_q_s = 32'hFFFF_FFFF;
    end else if (ovf_r) begin
      fin_q_s = 32'h8000_0000;
    end else begin
      fin_q_s = neg_q_r ? (32'd0 - quo_nxt_s) : quo_nxt_s;
    end

    if (ovf_r) begin
      fin_r_s = 32'd0;
    end else begin
      fin_r_s = neg_r_r ? (32'd0 - rem_nxt_s[31:0]) : rem_nxt_s[31:0];
    end

    fin_s = is_rem_r ? fin_r_s : fin_q_s;
  end

`ifdef DIV_EARLY_OUT_EN
  // Results that need no iteration: architectural specials and a divisor larger than the dividend
  always_comb begin
    early_s = dz_s | ovf_s | (a_mag_s < b_mag_s);
    if (dz_s) begin
      early_res_s = div_op_i[1] ? rs1_i : 32'hFFFF_FFFF;
    end else if (ovf_s) begin
      early_res_s = div_op_i[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      early_res_s = div_op_i[1] ? rs1_i : 32'd0;
    end
  end
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      rem_r    <= 33'd0;
      dvd_r    <= 32'd0;
      dvs_r    <= 32'd0;
      result_r <= 32'd0;
      cnt_r    <= 5'd0;
      is_rem_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (flush_i) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            rem_r    <= 33'd0;
            dvd_r    <= a_mag_s;
            dvs_r    <= b_mag_s;
            cnt_r    <= 5'd0;
            is_rem_r <= div_op_i[1];
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            dz_r     <= dz_s;
            ovf_r    <= ovf_s;
`ifdef DIV_EARLY_OUT_EN
            if (early_s) begin
              result_r <= early_res_s;
              state_r  <= DONE;
            end else begin
              state_r  <= CALC;
            end
`else
            state_r  <= CALC;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_nxt_s;
          dvd_r <= quo_nxt_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            result_r <= fin_s;
            state_r  <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
